// File: rtl/uk101_pkg.sv
// uk101_pkg: shared RX state encoding, baud constants and bit-period helper
package uk101_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam int BAUD_FAST = 9600;
  localparam int BAUD_SLOW = 300;
  function automatic logic [17:0] bit_period(input int clk_hz, input int baud);
    return 18'(clk_hz / baud);
  endfunction
endpackage

// File: rtl/uk101_save_capture_if.sv
// uk101_save_capture_if: hps_io ioctl upload (read) port
interface uk101_save_capture_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  modport master (output ioctl_upload, ioctl_rd, ioctl_addr, input ioctl_din);
  modport slave (input ioctl_upload, ioctl_rd, ioctl_addr, output ioctl_din);
endinterface

// File: rtl/uk101_serial_rx.sv
// uk101_serial_rx: 8N1 receiver for the ACIA TX line with a free-running idle bit tick
module uk101_serial_rx
  import uk101_pkg::*;
#(
  parameter int CLK_HZ = 48000000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       txd_i,
  input  logic       baud_rate_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_pulse_o,
  output logic       idle_tick_o
);
  localparam logic [17:0] BIT_F = bit_period(CLK_HZ, BAUD_FAST);
  localparam logic [17:0] BIT_S = bit_period(CLK_HZ, BAUD_SLOW);
  rx_state_t   state_q, state_d;
  logic [2:0]  sync_q;
  logic [17:0] cnt_q, cnt_d, per_q, per_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        brk_q, brk_d, valid_q, valid_d, err_q, err_d;
  logic        line, fall, tick;
  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = cnt_q == 18'd0;
  assign byte_valid_o = valid_q;
  assign byte_data_o = sh_q;
  assign frame_err_pulse_o = err_q;
  assign idle_tick_o = state_q == RX_IDLE && tick;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? cnt_q : cnt_q - 18'd1;
    per_d = state_q == RX_IDLE ? (baud_rate_i ? BIT_S : BIT_F) : per_q;
    bit_d = bit_q;
    sh_d = sh_q;
    brk_d = brk_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        state_d = fall ? RX_START : RX_IDLE;
        cnt_d = fall ? (per_d >> 1) - 18'd1 : tick ? per_d - 18'd1 : cnt_d;
      end
      RX_START: if (tick) begin
        state_d = line ? RX_IDLE : RX_DATA;
        cnt_d = line ? cnt_q : per_q - 18'd1;
        bit_d = 3'd0;
      end
      RX_DATA: if (tick) begin
        sh_d = {line, sh_q[7:1]};
        cnt_d = per_q - 18'd1;
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick) begin
        // a low stop bit flags once, then the frame is held until the line recovers
        state_d = line ? RX_IDLE : RX_STOP;
        valid_d = line & ~brk_q;
        err_d = ~line & ~brk_q;
        brk_d = ~line;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= RX_IDLE;
      sync_q <= 3'b111;
      cnt_q <= '0;
      per_q <= BIT_F;
      bit_q <= '0;
      sh_q <= '0;
      brk_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[1:0], txd_i};
      cnt_q <= cnt_d;
      per_q <= per_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      brk_q <= brk_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/uk101_save_capture.sv
// uk101_save_capture: captures ACIA SAVE/LIST output into RAM and serves it over ioctl upload
module uk101_save_capture
  import uk101_pkg::*;
#(
  parameter int         CLK_HZ    = 48000000,
  parameter int         ADDR_W    = 14,
  parameter int         IDLE_BITS = 40,
  parameter logic [7:0] PAD_BYTE  = 8'h1A
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  txd_i,
  input  logic                  baud_rate_i,
  input  logic                  arm_i,
  uk101_save_capture_if.slave   io,
  output logic [ADDR_W:0]       capture_len_o,
  output logic                  capture_done_o,
  output logic                  overflow_o,
  output logic                  frame_err_o
);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0] IB = IW'(IDLE_BITS);
  logic [7:0]    mem [2**ADDR_W];
  logic          bv, fe, itick, rise, take, wr;
  logic [7:0]    bd, ram_q;
  logic          arm_prev_q, armed_q, done_q, ovf_q, ferr_q, hit_q, vld_q;
  logic [ADDR_W:0] len_q;
  logic [IW-1:0] idle_q;
  uk101_serial_rx #(.CLK_HZ(CLK_HZ)) u_rx (
    .clk(clk), .n_reset(n_reset), .txd_i(txd_i), .baud_rate_i(baud_rate_i),
    .byte_valid_o(bv), .byte_data_o(bd), .frame_err_pulse_o(fe), .idle_tick_o(itick)
  );
  assign rise = arm_i & ~arm_prev_q;
  assign take = bv & armed_q & ~io.ioctl_upload & ~rise;
  assign wr = take & ~len_q[ADDR_W];
  assign capture_len_o = len_q;
  assign capture_done_o = done_q;
  assign overflow_o = ovf_q;
  assign frame_err_o = ferr_q;
  assign io.ioctl_din = vld_q ? (hit_q ? ram_q : PAD_BYTE) : 8'h00;
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      arm_prev_q <= 1'b0;
      armed_q <= 1'b0;
      len_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
      idle_q <= '0;
      hit_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      arm_prev_q <= arm_i;
      armed_q <= arm_i;
      len_q <= rise ? '0 : len_q + {{ADDR_W{1'b0}}, wr};
      ovf_q <= ~rise & (ovf_q | (take & len_q[ADDR_W]));
      ferr_q <= ~rise & (ferr_q | fe);
      idle_q <= (rise | bv) ? '0 : (itick && idle_q != IB) ? idle_q + IW'(1) : idle_q;
      done_q <= ~rise & ~bv & (done_q | (idle_q == IB && len_q != '0 && armed_q));
      hit_q <= io.ioctl_rd ? io.ioctl_addr < 16'(len_q) : hit_q;
      vld_q <= vld_q | io.ioctl_rd;
    end
  end
  // RAM ports carry no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr) mem[len_q[ADDR_W-1:0]] <= bd;
    if (io.ioctl_rd) ram_q <= mem[io.ioctl_addr[ADDR_W-1:0]];
  end
endmodule

// File: tb/tb_uk101_save_capture.sv
// tb_uk101_save_capture: directed bench; 96 kHz clock gives 10 clks/bit at 9600, 320 at 300
module tb_uk101_save_capture;
  logic clk = 1'b0, n_reset = 1'b0, txd = 1'b1, baud = 1'b0, arm = 1'b1;
  logic [4:0] len;
  logic done, ovf, ferr;
  int total = 0, bad = 0;
  uk101_save_capture_if io ();
  uk101_save_capture #(.CLK_HZ(96000), .ADDR_W(4), .IDLE_BITS(40), .PAD_BYTE(8'h1A)) dut (
    .clk(clk), .n_reset(n_reset), .txd_i(txd), .baud_rate_i(baud), .arm_i(arm), .io(io),
    .capture_len_o(len), .capture_done_o(done), .overflow_o(ovf), .frame_err_o(ferr)
  );
  always #5 clk = ~clk;
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int bc, input logic stop, input int arm_at, input int n);
    logic [10:0] fr;
    fr = {stop, stop, b, 1'b0};
    for (int c = 0; c < n; c++) begin
      txd = fr[c / bc];
      if (c == arm_at) arm = 1'b1;
      clks(1);
    end
    txd = 1'b1;
  endtask
  task automatic rd(input logic [15:0] a);
    io.ioctl_addr = a;
    io.ioctl_rd = 1'b1;
    clks(1);
    io.ioctl_rd = 1'b0;
  endtask
  initial begin
    logic [7:0] msg [9];
    logic [7:0] exp_up [10];
    msg = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49, 8'h4E, 8'h54, 8'h0D};
    exp_up = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49, 8'h4E, 8'h54, 8'h0D, 8'h1A};
    io.ioctl_upload = 1'b0;
    io.ioctl_rd = 1'b0;
    io.ioctl_addr = '0;
    clks(1);
    #2;
    clks(3);
    chk("rst_len", 32'(len), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_din", 32'(io.ioctl_din), 0);
    n_reset = 1'b1;
    clks(20);
    send(8'h41, 10, 1'b1, -1, 40);
    n_reset = 1'b0;
    clks(1);
    n_reset = 1'b1;
    chk("midrst_len", 32'(len), 0);
    chk("midrst_ferr", 32'(ferr), 0);
    clks(30);
    send(8'h41, 10, 1'b1, -1, 110);
    chk("t1_len", 32'(len), 1);
    io.ioctl_upload = 1'b1;
    rd(16'd0);
    chk("t1_ram0", 32'(io.ioctl_din), 32'h41);
    io.ioctl_upload = 1'b0;
    arm = 1'b0;
    clks(2);
    arm = 1'b1;
    clks(2);
    chk("rearm_len", 32'(len), 0);
    for (int i = 0; i < 9; i++) send(msg[i], 10, 1'b1, -1, 110);
    chk("t2_len", 32'(len), 9);
    clks(300);
    chk("t2_done_early", 32'(done), 0);
    clks(200);
    chk("t2_done", 32'(done), 1);
    io.ioctl_upload = 1'b1;
    for (int a = 0; a < 10; a++) begin
      rd(16'(a));
      chk($sformatf("t2_up%0d", a), 32'(io.ioctl_din), 32'(exp_up[a]));
    end
    clks(3);
    chk("t2_hold", 32'(io.ioctl_din), 32'h1A);
    io.ioctl_upload = 1'b0;
    baud = 1'b1;
    clks(5);
    send(8'h55, 320, 1'b1, -1, 11 * 320);
    chk("t3_len", 32'(len), 10);
    chk("t3_done_clr", 32'(done), 0);
    io.ioctl_upload = 1'b1;
    rd(16'd9);
    chk("t3_slow", 32'(io.ioctl_din), 32'h55);
    io.ioctl_upload = 1'b0;
    send(8'h55, 10, 1'b1, -1, 110);
    clks(400);
    chk("t3_wrongbaud", 32'(len), 10);
    baud = 1'b0;
    clks(5);
    send(8'h00, 10, 1'b0, -1, 110);
    clks(20);
    chk("t4_ferr", 32'(ferr), 1);
    chk("t4_len", 32'(len), 10);
    send(8'h0D, 10, 1'b1, -1, 110);
    chk("t4_len2", 32'(len), 11);
    io.ioctl_upload = 1'b1;
    rd(16'd10);
    chk("t4_ram", 32'(io.ioctl_din), 32'h0D);
    io.ioctl_upload = 1'b0;
    arm = 1'b0;
    clks(2);
    arm = 1'b1;
    clks(2);
    chk("t5_ferr_clr", 32'(ferr), 0);
    chk("t5_len0", 32'(len), 0);
    for (int i = 0; i < 17; i++) send(8'(8'h30 + i), 10, 1'b1, -1, 110);
    chk("t5_len", 32'(len), 16);
    chk("t5_ovf", 32'(ovf), 1);
    io.ioctl_upload = 1'b1;
    rd(16'd15);
    chk("t5_last", 32'(io.ioctl_din), 32'h3F);
    rd(16'd16);
    chk("t5_pad16", 32'(io.ioctl_din), 32'h1A);
    rd(16'h0020);
    chk("t5_nowrap", 32'(io.ioctl_din), 32'h1A);
    io.ioctl_upload = 1'b0;
    arm = 1'b0;
    clks(2);
    arm = 1'b1;
    clks(2);
    chk("t5_rearm_len", 32'(len), 0);
    chk("t5_rearm_ovf", 32'(ovf), 0);
    send(8'h42, 10, 1'b1, -1, 110);
    chk("t6_len1", 32'(len), 1);
    io.ioctl_upload = 1'b1;
    send(8'h43, 10, 1'b1, -1, 110);
    chk("t6_upload_drop", 32'(len), 1);
    io.ioctl_upload = 1'b0;
    arm = 1'b0;
    clks(3);
    chk("t6_retain", 32'(len), 1);
    send(8'h77, 10, 1'b1, 98, 110);
    clks(5);
    chk("t6_arm_vs_byte", 32'(len), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
